echo_distance_cm: RTL
=====================

// Module: echo_distance_cm
//
// PURPOSE
//   Downstream stage of the ultrasonic echo-duration counter. Watches the
//   same echo net the counter sees and captures echo_duration once, on each
//   echo falling edge. Converts the captured cycle count to centimetres with
//   a sequential restoring divider and presents the result with a one-cycle
//   valid strobe to display/control logic.
//
// PARAMETERS
//   CYCLES_PER_CM  2900  clk cycles per cm of range (50 MHz * 58 us); must be >= 1
//   MAX_CM         400   saturation limit for distance_cm (sensor max range)
//
// PORTS
//   clk            in   1   system clock; same domain as the echo counter
//   rst_n          in   1   asynchronous reset, active-low
//   echo           in   1   echo net, already synchronised; same net the counter uses
//   echo_duration  in   32  count from the echo counter; valid 1 cycle after echo falls
//   distance_cm    out  16  last converted distance, integer cm, truncated
//   dist_valid     out  1   1-cycle strobe: distance_cm/out_of_range just updated
//   out_of_range   out  1   1 when last result was clamped to MAX_CM
//   busy           out  1   1 while a capture/conversion is in progress
//   overrun        out  1   1-cycle strobe: echo fall while busy, measurement dropped
//
// BEHAVIOUR
//   Reset (rst_n=0, async): distance_cm=0, dist_valid=0, out_of_range=0,
//     busy=0, overrun=0, echo_d=0, state=IDLE, divider regs=0.
//   Fall detect: echo_d <= echo every edge; fall = echo_d & ~echo.
//   FSM states: IDLE, LATCH, DIV, DONE.
//     IDLE : fall -> LATCH (edge k).
//     LATCH: edge k+1 loads dividend=echo_duration, remainder=0, bit_cnt=31 -> DIV.
//     DIV  : one restoring step per edge, MSB first: rem={rem,dividend[bit]};
//            if rem>=CYCLES_PER_CM then rem-=CYCLES_PER_CM, q[bit]=1. bit_cnt=0 step -> DONE.
//            32 steps, edges k+2..k+33.
//     DONE : edge k+34 writes outputs, dist_valid=1 for exactly that cycle -> IDLE.
//   Latency: dist_valid high in the cycle after edge k+34 (34 clks after fall seen).
//   busy=1 in LATCH, DIV, DONE; 0 in IDLE.
//   Widths: dividend/quotient 32 bit, remainder 33 bit (no overflow on compare).
//   Saturation: q > MAX_CM -> distance_cm=MAX_CM, out_of_range=1;
//     else distance_cm=q[15:0], out_of_range=0.
//   Zero duration: echo_duration=0 -> distance_cm=0, out_of_range=0, normal strobe.
//   Fall while busy (LATCH/DIV/DONE): ignored, overrun=1 one cycle; conversion continues.
//   Fall in the same cycle dist_valid is high (state IDLE again): accepted normally.
//   distance_cm and out_of_range hold their value between strobes.
//   Reset mid-conversion: aborts immediately; outputs return to reset values, no strobe.
//   echo high at reset release: no fall until it drops; that fall is converted normally.
//
// TESTING
//   1 echo high 29000 clks then low -> 34 clks after fall: distance_cm=10,
//     dist_valid 1 clk, out_of_range=0.
//   2 echo_duration=2899 -> distance_cm=0; 2900 -> 1; 5799 -> 1 (truncation).
//   3 echo_duration=1_200_000 (413 cm) -> distance_cm=400, out_of_range=1;
//     then 58000 -> distance_cm=20, out_of_range=0.
//   4 second echo fall 10 clks after first -> overrun pulses 1 clk,
//     only first result strobed; fall after return to IDLE -> converted.
//   5 rst_n low at DIV step 15 -> outputs 0 at once, busy=0, no dist_valid;
//     next echo converts correctly.
//   6 echo_duration=0xFFFF_FFFF -> distance_cm=400, out_of_range=1, no X on any output.

Source files
------------

// File: rtl/echo_distance_cm.sv
// echo_distance_cm: captures echo_duration on each echo falling edge and converts
// it to whole centimetres with a 32-step restoring divider. Rev 1.0
`default_nettype none

module echo_distance_cm #(
  parameter int CYCLES_PER_CM = 2900,
  parameter int MAX_CM        = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  input  logic [31:0] echo_duration,
  output logic [15:0] distance_cm,
  output logic        dist_valid,
  output logic        out_of_range,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [32:0] DIVISOR = 33'(CYCLES_PER_CM);
  localparam logic [31:0] MAX_Q   = 32'(MAX_CM);

  state_t      state;
  state_t      state_nx;
  logic        echo_d;
  logic        fall;
  logic [31:0] dividend;
  logic [31:0] quotient;
  logic [32:0] remainder;
  logic [4:0]  bit_cnt;
  logic [32:0] rem_shift;
  logic [32:0] rem_next;
  logic        q_bit;

  assign fall = echo_d & ~echo;

  // Dividend is shifted left each step, so its MSB is always the bit being brought down.
  always_comb begin
    rem_shift = 33'({remainder, dividend[31]});
    rem_next  = rem_shift;
    q_bit     = 1'b0;
    if (rem_shift >= DIVISOR) begin
      rem_next = rem_shift - DIVISOR;
      q_bit    = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (fall) state_nx = LATCH;
      LATCH:   state_nx = DIV;
      DIV:     if (bit_cnt == 5'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      echo_d       <= 1'b0;
      dividend     <= '0;
      quotient     <= '0;
      remainder    <= '0;
      bit_cnt      <= '0;
      distance_cm  <= '0;
      out_of_range <= 1'b0;
      dist_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state      <= state_nx;
      echo_d     <= echo;
      dist_valid <= 1'b0;
      overrun    <= fall && (state != IDLE);
      case (state)
        LATCH: begin
          dividend  <= echo_duration;
          remainder <= '0;
          quotient  <= '0;
          bit_cnt   <= 5'd31;
        end
        DIV: begin
          dividend  <= {dividend[30:0], 1'b0};
          remainder <= rem_next;
          quotient  <= {quotient[30:0], q_bit};
          bit_cnt   <= bit_cnt - 5'd1;
        end
        DONE: begin
          dist_valid <= 1'b1;
          if (quotient > MAX_Q) begin
            distance_cm  <= MAX_Q[15:0];
            out_of_range <= 1'b1;
          end else begin
            distance_cm  <= quotient[15:0];
            out_of_range <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
